bt_search_ctrl: RTL and testbench

Parametrised backtracking-search controller: the next generation of the push/ALU/backtrack/pop sequencer.
- Adds an internal stack-pointer counter with overflow protection.
- Adds a configurable multi-cycle ALU wait, an iteration limit with timeout, and a start/busy/done handshake with sticky error flags.
- Drives the datapath's init, push, alu, pop, result and update strobes.

---
 rtl/bt_ctrl_pkg.sv | 61 ++++++
 rtl/bt_wait_timer.sv | 35 +++
 rtl/bt_search_ctrl.sv | 136 +++++++++++++
 tb/tb_bt_search_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bt_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bt_ctrl_pkg
// Shared types and helpers for the backtracking-search controller.
//   bt_state_t : controller state, 4-bit binary, IDLE = 0
//   bt_ctrl_t  : bundle of state-decoded controller outputs
//   width_of   : bits needed to hold the value n (minimum 1)
//   decode     : Moore output decode for a given state
// ---------------------------------------------------------------------------
package bt_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      INIT    = 4'd1,
      MULT    = 4'd2,
      PUSH    = 4'd3,
      ALU     = 4'd4,
      BACK    = 4'd5,
      POP_CHK = 4'd6,
      POP     = 4'd7,
      UPDATE  = 4'd8,
      DONE    = 4'd9,
      ERR     = 4'd10
   } bt_state_t;

   typedef struct packed {
      logic load_init;
      logic push;
      logic alu_en;
      logic cal_res;
      logic pop;
      logic res_update;
      logic done;
      logic dont_check;
      logic busy;
   } bt_ctrl_t;

   function automatic int width_of(input int n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

   function automatic bt_ctrl_t decode(input bt_state_t s);
      bt_ctrl_t c;
      c      = '0;
      c.busy = (s != IDLE);
      case (s)
         IDLE:    c.dont_check = 1'b1;
         INIT:    begin c.load_init = 1'b1; c.dont_check = 1'b1; end
         MULT:    c.dont_check = 1'b1;
         PUSH:    begin c.push = 1'b1; c.dont_check = 1'b1; end
         ALU:     c.alu_en = 1'b1;
         POP_CHK: c.cal_res = 1'b1;
         POP:     c.pop = 1'b1;
         UPDATE:  c.res_update = 1'b1;
         DONE,
         ERR:     c.done = 1'b1;
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/bt_wait_timer.sv
// ---------------------------------------------------------------------------
// bt_wait_timer
// Loadable down-counter used to hold a state for LAT cycles.
//   clk, rst : clock, asynchronous active-high reset
//   load     : reload count with LAT (wins over en)
//   en       : decrement by one (stops at zero)
//   expired  : count == 1, i.e. this is the last cycle of the wait
// ---------------------------------------------------------------------------
module bt_wait_timer
   import bt_ctrl_pkg::*;
#(
   parameter int LAT = 1,
   parameter int W   = width_of(LAT)
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (load)
         cnt <= W'(LAT);
      else if (en && (cnt != '0))
         cnt <= cnt - W'(1);
   end

   assign expired = (cnt == W'(1));

endmodule

// File: rtl/bt_search_ctrl.sv
// ---------------------------------------------------------------------------
// bt_search_ctrl
// Push/ALU/backtrack/pop sequencer for a backtracking-search datapath.
// Optional feature: define BT_HOLD_EN to add the hold input (freeze + mute).
//   clk, rst   : clock, asynchronous active-high reset
//   hold       : (BT_HOLD_EN only) freeze progress, force strobes low
//   start      : begin a search (sampled in IDLE)
//   backtrack  : unwind request (sampled in BACK)
//   finish     : solution/exhausted (sampled in POP_CHK)
//   load_init, push, alu_en, cal_res, pop, res_update : datapath strobes
//   dont_check : suppress datapath checker
//   busy, done : handshake (done is a one-cycle pulse)
//   overflow, timeout : sticky error flags, cleared by an accepted start
//   sp, iter_cnt      : stack depth and UPDATE passes of this run
// ---------------------------------------------------------------------------
module bt_search_ctrl
   import bt_ctrl_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int ALU_LAT  = 1,
   parameter int MAX_ITER = 1024,
   parameter int SP_W     = $clog2(DEPTH + 1),
   parameter int IT_W     = $clog2(MAX_ITER + 1)
) (
   input  logic            clk,
   input  logic            rst,
`ifdef BT_HOLD_EN
   input  logic            hold,
`endif
   input  logic            start,
   input  logic            backtrack,
   input  logic            finish,
   output logic            load_init,
   output logic            push,
   output logic            alu_en,
   output logic            cal_res,
   output logic            pop,
   output logic            res_update,
   output logic            dont_check,
   output logic            busy,
   output logic            done,
   output logic            overflow,
   output logic            timeout,
   output logic [SP_W-1:0] sp,
   output logic [IT_W-1:0] iter_cnt
);

   localparam logic [SP_W-1:0] SP_MAX  = SP_W'(DEPTH);
   localparam logic [IT_W-1:0] IT_MAX  = IT_W'(MAX_ITER);
   localparam logic [IT_W-1:0] IT_LAST = IT_W'(MAX_ITER - 1);

   bt_state_t state, nxt;
   bt_ctrl_t  ctrl_q;
   logic      adv;       // FSM and counters may move this cycle
   logic      strobe_ok; // strobes allowed to reach the datapath
   logic      alu_done;

`ifdef BT_HOLD_EN
   assign adv       = ~hold;
   assign strobe_ok = ~hold;
`else
   assign adv       = 1'b1;
   assign strobe_ok = 1'b1;
`endif

   // Reload on the PUSH->ALU edge so every evaluation gets the full wait;
   // a hold freezes the count because en drops with adv.
   bt_wait_timer #(.LAT(ALU_LAT)) u_alu_wait (
      .clk     (clk),
      .rst     (rst),
      .load    (adv && (state == PUSH)),
      .en      (adv && (state == ALU)),
      .expired (alu_done)
   );

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = INIT;
         INIT:    nxt = MULT;
         MULT:    nxt = (sp == SP_MAX) ? ERR : PUSH;
         PUSH:    nxt = ALU;
         ALU:     if (alu_done) nxt = BACK;
         BACK:    nxt = backtrack ? POP_CHK : UPDATE;
         POP_CHK: nxt = (finish || (sp == '0)) ? DONE : POP;
         POP:     nxt = POP_CHK;
         UPDATE:  nxt = (iter_cnt == IT_LAST) ? ERR : MULT;
         DONE,
         ERR:     nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they decode, without a combinational path from the state reg.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ctrl_q   <= decode(IDLE);
         sp       <= '0;
         iter_cnt <= '0;
         overflow <= 1'b0;
         timeout  <= 1'b0;
      end else if (adv) begin
         state  <= nxt;
         ctrl_q <= decode(nxt);
         case (state)
            IDLE: if (start) begin
               overflow <= 1'b0;
               timeout  <= 1'b0;
               sp       <= '0;
               iter_cnt <= '0;
            end
            MULT: if (sp == SP_MAX) overflow <= 1'b1;
            PUSH: if (sp != SP_MAX) sp <= sp + SP_W'(1);
            POP:  if (sp != '0) sp <= sp - SP_W'(1);
            UPDATE: begin
               if (iter_cnt != IT_MAX) iter_cnt <= iter_cnt + IT_W'(1);
               if (iter_cnt == IT_LAST) timeout <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign load_init  = ctrl_q.load_init  & strobe_ok;
   assign push       = ctrl_q.push       & strobe_ok;
   assign alu_en     = ctrl_q.alu_en     & strobe_ok;
   assign cal_res    = ctrl_q.cal_res    & strobe_ok;
   assign pop        = ctrl_q.pop        & strobe_ok;
   assign res_update = ctrl_q.res_update & strobe_ok;
   assign done       = ctrl_q.done       & strobe_ok;
   assign dont_check = ctrl_q.dont_check;
   assign busy       = ctrl_q.busy;

endmodule

// File: tb/tb_bt_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bt_search_ctrl
// Two controllers: A (DEPTH=8, ALU_LAT=1, MAX_ITER=4) reaches the iteration
// limit, B (DEPTH=2, ALU_LAT=3, MAX_ITER=16) reaches stack overflow. A
// procedural model walks one search at a time and publishes the expected
// outputs every cycle; literal checks pin a few hand-derived timelines.
// ---------------------------------------------------------------------------
module tb_bt_search_ctrl;

   logic clk = 1'b0, rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0, backtrack = 1'b0, finish = 1'b0, hold_s = 1'b0;
   always #5 clk = ~clk;

   logic li_a, pu_a, al_a, cr_a, po_a, ru_a, dn_a, dc_a, bs_a, ov_a, to_a;
   logic [3:0] sp_a;
   logic [2:0] it_a;
   logic li_b, pu_b, al_b, cr_b, po_b, ru_b, dn_b, dc_b, bs_b, ov_b, to_b;
   logic [1:0] sp_b;
   logic [4:0] it_b;

   bt_search_ctrl #(.DEPTH(8), .ALU_LAT(1), .MAX_ITER(4)) u_a (
      .clk(clk), .rst(rst),
`ifdef BT_HOLD_EN
      .hold(hold_s),
`endif
      .start(start_a), .backtrack(backtrack), .finish(finish),
      .load_init(li_a), .push(pu_a), .alu_en(al_a), .cal_res(cr_a), .pop(po_a),
      .res_update(ru_a), .dont_check(dc_a), .busy(bs_a), .done(dn_a),
      .overflow(ov_a), .timeout(to_a), .sp(sp_a), .iter_cnt(it_a));

   bt_search_ctrl #(.DEPTH(2), .ALU_LAT(3), .MAX_ITER(16)) u_b (
      .clk(clk), .rst(rst),
`ifdef BT_HOLD_EN
      .hold(hold_s),
`endif
      .start(start_b), .backtrack(backtrack), .finish(finish),
      .load_init(li_b), .push(pu_b), .alu_en(al_b), .cal_res(cr_b), .pop(po_b),
      .res_update(ru_b), .dont_check(dc_b), .busy(bs_b), .done(dn_b),
      .overflow(ov_b), .timeout(to_b), .sp(sp_b), .iter_cnt(it_b));

   typedef struct packed {
      logic li, pu, al, cr, po, ru, dn, dc, bsy, ovf, tmo;
      logic [7:0]  sp;
      logic [15:0] it;
   } exp_t;

   localparam exp_t RST_E = {7'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0};

   exp_t e[2];
   int   m_sp[2], m_it[2];
   logic m_ovf[2], m_tmo[2];
   logic m_idle = 1'b1;
   int   m_act = 0;
   logic ab, s_st_a, s_st_b, s_bt, s_fn;

   int   n_chk = 0, n_fail = 0;
   logic chk_en = 1'b0;
   int   dir = 0, cyc = 0;
   int   c_ru, c_pu, c_alu, c_po, c_cr;

   // ---------------- behavioural model ----------------
   task automatic show(input int w, input logic [6:0] s, input logic dc, input logic bsy);
      e[w] = {s, dc, bsy, m_ovf[w], m_tmo[w], 8'(m_sp[w]), 16'(m_it[w])};
   endtask

   task automatic reset_model();
      for (int w = 0; w < 2; w++) begin
         m_sp[w] = 0; m_it[w] = 0; m_ovf[w] = 1'b0; m_tmo[w] = 1'b0;
         show(w, 7'b0, 1'b1, 1'b0);
      end
      m_idle = 1'b1;
   endtask

   // One controller step: held edges do not count, a reset edge aborts.
   task automatic tick();
      forever begin
         @(posedge clk);
         if (rst) begin ab = 1'b1; break; end
         if (!hold_s) break;
      end
      s_st_a = start_a; s_st_b = start_b; s_bt = backtrack; s_fn = finish;
   endtask

   // One complete search, from the cycle after start was accepted.
   task automatic run(input int w, input int D, input int L, input int M);
      logic unwind;
      unwind = 1'b0;
      m_idle = 1'b0;
      m_ovf[w] = 1'b0; m_tmo[w] = 1'b0; m_sp[w] = 0; m_it[w] = 0;
      show(w, 7'b1000000, 1'b1, 1'b1); tick(); if (ab) return;        // init
      forever begin
         show(w, 7'b0, 1'b1, 1'b1); tick(); if (ab) return;           // overflow check
         if (m_sp[w] == D) begin m_ovf[w] = 1'b1; break; end
         show(w, 7'b0100000, 1'b1, 1'b1); tick(); if (ab) return;     // push
         m_sp[w]++;
         repeat (L) begin
            show(w, 7'b0010000, 1'b0, 1'b1); tick(); if (ab) return;  // alu
         end
         show(w, 7'b0, 1'b0, 1'b1); tick(); if (ab) return;           // backtrack decision
         if (s_bt) begin unwind = 1'b1; break; end
         show(w, 7'b0000010, 1'b0, 1'b1); tick(); if (ab) return;     // update
         m_it[w]++;
         if (m_it[w] == M) begin m_tmo[w] = 1'b1; break; end
      end
      if (unwind) begin
         forever begin
            show(w, 7'b0001000, 1'b0, 1'b1); tick(); if (ab) return;  // result
            if (s_fn || m_sp[w] == 0) break;
            show(w, 7'b0000100, 1'b0, 1'b1); tick(); if (ab) return;  // pop
            m_sp[w]--;
         end
      end
      show(w, 7'b0000001, 1'b0, 1'b1); tick(); if (ab) return;        // done pulse
      show(w, 7'b0, 1'b1, 1'b0);
      m_idle = 1'b1;
   endtask

   initial begin
      reset_model();
      wait (!rst);
      forever begin
         ab = 1'b0;
         tick();
         if (!ab) begin
            if (s_st_a) begin m_act = 0; run(0, 8, 1, 4); end
            else if (s_st_b) begin m_act = 1; run(1, 2, 3, 16); end
         end
         if (ab) begin reset_model(); wait (!rst); end
      end
   end

   // ---------------- compare ----------------
   task automatic chk(input string name, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      exp_t act, ex;
      if (chk_en) begin
         for (int w = 0; w < 2; w++) begin
            act = (w == 0) ?
               {li_a, pu_a, al_a, cr_a, po_a, ru_a, dn_a, dc_a, bs_a, ov_a, to_a, 8'(sp_a), 16'(it_a)} :
               {li_b, pu_b, al_b, cr_b, po_b, ru_b, dn_b, dc_b, bs_b, ov_b, to_b, 8'(sp_b), 16'(it_b)};
            ex = rst ? RST_E : e[w];
            if (!rst && hold_s) ex[34:28] = 7'b0;
            n_chk++;
            if (act !== ex) begin
               n_fail++;
               $display("FAIL model_%0d t=%0t: dut=%h exp=%h", w, $time, act, ex);
            end
         end
         if (dir != 0 && cyc == 0) begin
            c_ru = 0; c_pu = 0; c_alu = 0; c_po = 0; c_cr = 0;
         end else begin
            c_ru += int'(ru_a); c_pu += int'(pu_b); c_alu += int'(al_b);
            c_po += int'(po_a); c_cr += int'(cr_a);
         end
         case (dir)
            1: begin
               if (cyc == 1) chk("a_load_init_c1", int'(li_a), 1);
               if (cyc == 22) begin
                  chk("a_err_done", int'(dn_a), 1);
                  chk("a_timeout", int'(to_a), 1);
                  chk("a_iter_cnt", int'(it_a), 4);
                  chk("a_sp", int'(sp_a), 4);
                  chk("a_res_update_cnt", c_ru, 4);
                  chk("model_a_done", int'(e[0].dn), 1);
               end
               if (cyc == 23) chk("a_busy_fall", int'(bs_a), 0);
            end
            2: begin
               if (cyc == 6) chk("b_alu_third", int'(al_b), 1);
               if (cyc == 7) chk("b_alu_off_back", int'(al_b), 0);
               if (cyc == 17) begin
                  chk("b_err_done", int'(dn_b), 1);
                  chk("b_overflow", int'(ov_b), 1);
                  chk("b_sp", int'(sp_b), 2);
                  chk("b_iter_cnt", int'(it_b), 2);
                  chk("model_b_overflow", int'(e[1].ovf), 1);
               end
               if (cyc == 19) begin
                  chk("b_push_cnt", c_pu, 2);
                  chk("b_alu_cnt", c_alu, 6);
               end
            end
            3: begin
               if (cyc == 16) chk("a_bt_sp_peak", int'(sp_a), 3);
               if (cyc == 23) begin
                  chk("a_bt_done", int'(dn_a), 1);
                  chk("a_bt_sp_zero", int'(sp_a), 0);
                  chk("a_bt_no_flags", int'(ov_a) + int'(to_a), 0);
                  chk("a_bt_pop_cnt", c_po, 3);
                  chk("a_bt_cal_res_cnt", c_cr, 4);
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic dir_run(input int d, input int n);
      @(posedge clk); #2;
      dir = d; cyc = 0; backtrack = 1'b0; finish = 1'b0;
      if (d == 2) start_b = 1'b1; else start_a = 1'b1;
      for (int c = 1; c <= n; c++) begin
         @(posedge clk); #2;
         cyc = c; start_a = 1'b0; start_b = 1'b0;
         backtrack = (d == 3 && c >= 12);
      end
      @(posedge clk); #2;
      dir = 0; backtrack = 1'b0;
   endtask

   initial begin
      int rst_cnt, r;
      rst_cnt = 0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      dir_run(1, 25);
      dir_run(2, 20);
      dir_run(3, 26);
      for (int i = 0; i < 6000; i++) begin
         @(posedge clk); #2;
         if (rst_cnt > 0) begin
            rst_cnt--;
            if (rst_cnt == 0) rst = 1'b0;
         end else if ($urandom_range(0, 799) == 0) begin
            rst = 1'b1; rst_cnt = 2;
         end
         backtrack = ($urandom_range(0, 3) == 0);
         finish    = ($urandom_range(0, 3) == 0);
`ifdef BT_HOLD_EN
         hold_s    = ($urandom_range(0, 7) == 0);
`endif
         if (m_idle) begin
            r = int'($urandom_range(0, 3));
            start_a = (r == 1); start_b = (r == 2);
         end else begin
            start_a = (m_act == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            start_b = (m_act == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      @(posedge clk); #2;
      start_a = 1'b0; start_b = 1'b0; rst = 1'b0; hold_s = 1'b0;
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
